// File: rtl/lc3_ctrl_pkg.sv
// Shared constants for the LC-3b hardwired control unit: state numbers,
// control-word bit positions, mux/ALU encodings and opcodes.
package lc3_ctrl_pkg;

  localparam int unsigned CW_W    = 26;
  localparam int unsigned STATE_W = 6;

  typedef enum logic [5:0] {
    S_BR       = 6'd0,
    S_ADD      = 6'd1,
    S_LDB      = 6'd2,
    S_STB      = 6'd3,
    S_JSR      = 6'd4,
    S_AND      = 6'd5,
    S_LDW      = 6'd6,
    S_STW      = 6'd7,
    S_XOR      = 6'd9,
    S_JMP      = 6'd12,
    S_SHF      = 6'd13,
    S_LEA      = 6'd14,
    S_TRAP     = 6'd15,
    S_STW_WR   = 6'd16,
    S_STB_WR   = 6'd17,
    S_FETCH    = 6'd18,
    S_JSRR     = 6'd20,
    S_JSR_OFF  = 6'd21,
    S_BR_TAKEN = 6'd22,
    S_STW_MDR  = 6'd23,
    S_STB_MDR  = 6'd24,
    S_LDW_RD   = 6'd25,
    S_LDW_WB   = 6'd27,
    S_TRAP_RD  = 6'd28,
    S_LDB_RD   = 6'd29,
    S_TRAP_PC  = 6'd30,
    S_LDB_WB   = 6'd31,
    S_DECODE   = 6'd32,
    S_FETCH_RD = 6'd33,
    S_FETCH_IR = 6'd35
  } state_t;

  localparam int unsigned B_LOAD_MAR    = 25;
  localparam int unsigned B_LOAD_MDR    = 24;
  localparam int unsigned B_LOAD_IR     = 23;
  localparam int unsigned B_LOAD_BEN    = 22;
  localparam int unsigned B_LOAD_REG    = 21;
  localparam int unsigned B_LOAD_CC     = 20;
  localparam int unsigned B_LOAD_PC     = 19;
  localparam int unsigned B_GATE_PC     = 18;
  localparam int unsigned B_GATE_MDR    = 17;
  localparam int unsigned B_GATE_ALU    = 16;
  localparam int unsigned B_GATE_MARMUX = 15;
  localparam int unsigned B_GATE_SHF    = 14;
  localparam int unsigned B_PC_MUX_HI   = 13;
  localparam int unsigned B_PC_MUX_LO   = 12;
  localparam int unsigned B_DR_MUX      = 11;
  localparam int unsigned B_SR1_MUX     = 10;
  localparam int unsigned B_ADDR1_MUX   = 9;
  localparam int unsigned B_ADDR2_HI    = 8;
  localparam int unsigned B_ADDR2_LO    = 7;
  localparam int unsigned B_MAR_MUX     = 6;
  localparam int unsigned B_ALUK_HI     = 5;
  localparam int unsigned B_ALUK_LO     = 4;
  localparam int unsigned B_MIO_EN      = 3;
  localparam int unsigned B_R_W         = 2;
  localparam int unsigned B_DATA_SIZE   = 1;
  localparam int unsigned B_LSHF1       = 0;

  localparam logic [1:0] PCMUX_PC2   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_XOR   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [3:0] OP_BR   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LDB  = 4'd2;
  localparam logic [3:0] OP_STB  = 4'd3;
  localparam logic [3:0] OP_JSR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_LDW  = 4'd6;
  localparam logic [3:0] OP_STW  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_SHF  = 4'd13;
  localparam logic [3:0] OP_LEA  = 4'd14;
  localparam logic [3:0] OP_TRAP = 4'd15;

endpackage

// File: rtl/control_store.sv
// Combinational control store: maps the current state to its raw 26-bit
// control word (load_mdr not yet qualified by memory ready).
module control_store
  import lc3_ctrl_pkg::*;
(
  input  state_t          st,
  output logic [CW_W-1:0] word
);

  always_comb begin
    word = '0;
    case (st)
      S_FETCH: begin
        word[B_LOAD_MAR] = 1'b1;
        word[B_GATE_PC]  = 1'b1;
        word[B_LOAD_PC]  = 1'b1;
        word[B_PC_MUX_HI:B_PC_MUX_LO] = PCMUX_PC2;
      end
      S_FETCH_RD, S_LDW_RD: begin
        word[B_LOAD_MDR]  = 1'b1;
        word[B_MIO_EN]    = 1'b1;
        word[B_DATA_SIZE] = 1'b1;
      end
      S_FETCH_IR: begin
        word[B_LOAD_IR]  = 1'b1;
        word[B_GATE_MDR] = 1'b1;
      end
      S_DECODE: word[B_LOAD_BEN] = 1'b1;
      S_ADD, S_AND, S_XOR: begin
        word[B_LOAD_REG] = 1'b1;
        word[B_LOAD_CC]  = 1'b1;
        word[B_GATE_ALU] = 1'b1;
        word[B_SR1_MUX]  = 1'b1;
        word[B_ALUK_HI:B_ALUK_LO] = (st == S_ADD) ? ALUK_ADD :
                                    (st == S_AND) ? ALUK_AND : ALUK_XOR;
      end
      S_SHF: begin
        word[B_LOAD_REG] = 1'b1;
        word[B_LOAD_CC]  = 1'b1;
        word[B_GATE_SHF] = 1'b1;
        word[B_SR1_MUX]  = 1'b1;
      end
      S_LEA: begin
        word[B_LOAD_REG]    = 1'b1;
        word[B_GATE_MARMUX] = 1'b1;
        word[B_MAR_MUX]     = 1'b1;
        word[B_ADDR2_HI:B_ADDR2_LO] = ADDR2_OFF9;
        word[B_LSHF1]       = 1'b1;
      end
      S_BR_TAKEN, S_JSR_OFF: begin
        word[B_LOAD_PC] = 1'b1;
        word[B_PC_MUX_HI:B_PC_MUX_LO] = PCMUX_ADDER;
        word[B_ADDR2_HI:B_ADDR2_LO] = (st == S_JSR_OFF) ? ADDR2_OFF11 : ADDR2_OFF9;
        word[B_LSHF1]   = 1'b1;
      end
      // BaseR comes from IR[8:6] through the SR1 port
      S_JMP, S_JSRR: begin
        word[B_LOAD_PC]   = 1'b1;
        word[B_PC_MUX_HI:B_PC_MUX_LO] = PCMUX_ADDER;
        word[B_SR1_MUX]   = 1'b1;
        word[B_ADDR1_MUX] = 1'b1;
        word[B_ADDR2_HI:B_ADDR2_LO] = ADDR2_ZERO;
      end
      S_JSR: begin
        word[B_LOAD_REG] = 1'b1;
        word[B_DR_MUX]   = 1'b1;
        word[B_GATE_PC]  = 1'b1;
      end
      S_LDW, S_STW, S_LDB, S_STB: begin
        word[B_LOAD_MAR]    = 1'b1;
        word[B_GATE_MARMUX] = 1'b1;
        word[B_MAR_MUX]     = 1'b1;
        word[B_SR1_MUX]     = 1'b1;
        word[B_ADDR1_MUX]   = 1'b1;
        word[B_ADDR2_HI:B_ADDR2_LO] = ADDR2_OFF6;
        word[B_LSHF1]       = (st == S_LDW) || (st == S_STW);
      end
      S_LDW_WB, S_LDB_WB: begin
        word[B_LOAD_REG]  = 1'b1;
        word[B_LOAD_CC]   = 1'b1;
        word[B_GATE_MDR]  = 1'b1;
        word[B_DATA_SIZE] = (st == S_LDW_WB);
      end
      S_LDB_RD: begin
        word[B_LOAD_MDR] = 1'b1;
        word[B_MIO_EN]   = 1'b1;
      end
      S_STW_MDR, S_STB_MDR: begin
        word[B_LOAD_MDR]  = 1'b1;
        word[B_GATE_ALU]  = 1'b1;
        word[B_ALUK_HI:B_ALUK_LO] = ALUK_PASSA;
        word[B_DATA_SIZE] = (st == S_STW_MDR);
      end
      S_STW_WR, S_STB_WR: begin
        word[B_MIO_EN]    = 1'b1;
        word[B_R_W]       = 1'b1;
        word[B_DATA_SIZE] = (st == S_STW_WR);
      end
      S_TRAP: begin
        word[B_LOAD_MAR]    = 1'b1;
        word[B_GATE_MARMUX] = 1'b1;
      end
      S_TRAP_RD: begin
        word[B_LOAD_MDR]  = 1'b1;
        word[B_MIO_EN]    = 1'b1;
        word[B_DATA_SIZE] = 1'b1;
        word[B_LOAD_REG]  = 1'b1;
        word[B_DR_MUX]    = 1'b1;
        word[B_GATE_PC]   = 1'b1;
      end
      S_TRAP_PC: begin
        word[B_LOAD_PC]   = 1'b1;
        word[B_GATE_MDR]  = 1'b1;
        word[B_PC_MUX_HI:B_PC_MUX_LO] = PCMUX_BUS;
        word[B_DATA_SIZE] = 1'b1;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// LC-3b hardwired control FSM: state register, next-state logic and
// output gating around the control store.
module control_unit
  import lc3_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         ir_op,
  input  logic               ir11,
  input  logic               ben,
  input  logic               mem_ready,
  output logic [CW_W-1:0]    control_signals,
  output logic [STATE_W-1:0] state
);

  state_t          cur_state;
  state_t          nxt_state;
  logic [CW_W-1:0] rom_word;
  logic [CW_W-1:0] gated_word;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:    nxt_state = S_FETCH_RD;
      S_FETCH_RD: nxt_state = mem_ready ? S_FETCH_IR : S_FETCH_RD;
      S_FETCH_IR: nxt_state = S_DECODE;
      S_DECODE: begin
        case (ir_op)
          OP_BR:   nxt_state = S_BR;
          OP_ADD:  nxt_state = S_ADD;
          OP_LDB:  nxt_state = S_LDB;
          OP_STB:  nxt_state = S_STB;
          OP_JSR:  nxt_state = S_JSR;
          OP_AND:  nxt_state = S_AND;
          OP_LDW:  nxt_state = S_LDW;
          OP_STW:  nxt_state = S_STW;
          OP_XOR:  nxt_state = S_XOR;
          OP_JMP:  nxt_state = S_JMP;
          OP_SHF:  nxt_state = S_SHF;
          OP_LEA:  nxt_state = S_LEA;
          OP_TRAP: nxt_state = S_TRAP;
          default: nxt_state = S_FETCH;
        endcase
      end
      S_BR:      nxt_state = ben ? S_BR_TAKEN : S_FETCH;
      S_JSR:     nxt_state = ir11 ? S_JSR_OFF : S_JSRR;
      S_LDW:     nxt_state = S_LDW_RD;
      S_LDW_RD:  nxt_state = mem_ready ? S_LDW_WB : S_LDW_RD;
      S_LDB:     nxt_state = S_LDB_RD;
      S_LDB_RD:  nxt_state = mem_ready ? S_LDB_WB : S_LDB_RD;
      S_STW:     nxt_state = S_STW_MDR;
      S_STW_MDR: nxt_state = S_STW_WR;
      S_STW_WR:  nxt_state = mem_ready ? S_FETCH : S_STW_WR;
      S_STB:     nxt_state = S_STB_MDR;
      S_STB_MDR: nxt_state = S_STB_WR;
      S_STB_WR:  nxt_state = mem_ready ? S_FETCH : S_STB_WR;
      S_TRAP:    nxt_state = S_TRAP_RD;
      S_TRAP_RD: nxt_state = mem_ready ? S_TRAP_PC : S_TRAP_RD;
      default:   nxt_state = S_FETCH;
    endcase
  end

  control_store u_store (
    .st   (cur_state),
    .word (rom_word)
  );

  // Memory reads capture MDR only in the cycle the data is valid
  always_comb begin
    gated_word = rom_word;
    if (rom_word[B_MIO_EN] && !rom_word[B_R_W])
      gated_word[B_LOAD_MDR] = rom_word[B_LOAD_MDR] & mem_ready;
    if (reset)
      gated_word = '0;
  end

  assign control_signals = gated_word;
  assign state           = cur_state;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit with hand-computed words.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ir_op;
  logic        ir11;
  logic        ben;
  logic        mem_ready;
  logic [25:0] control_signals;
  logic [5:0]  state;

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .clk             (clk),
    .reset           (reset),
    .ir_op           (ir_op),
    .ir11            (ir11),
    .ben             (ben),
    .mem_ready       (mem_ready),
    .control_signals (control_signals),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] es, input logic [25:0] ew);
    #1;
    checks++;
    assert (state === es && control_signals === ew)
    else begin
      failures++;
      $error("FAIL %s: state=%0d expected %0d, word=%h expected %h",
             tag, state, es, control_signals, ew);
    end
  endtask

  task automatic chk_word(input string tag, input logic [25:0] ew);
    #1;
    checks++;
    assert (control_signals === ew)
    else begin
      failures++;
      $error("FAIL %s: word=%h expected %h", tag, control_signals, ew);
    end
  endtask

  task automatic fetch();
    tick(); chk("fetch33", 6'd33, 26'h100000A);
    tick(); chk("fetch35", 6'd35, 26'h0820000);
    tick(); chk("fetch32", 6'd32, 26'h0400000);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; ir_op = 4'd0; ir11 = 1'b0; ben = 1'b0;

    // Reset held three cycles
    chk_word("rst_pre", 26'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("rst_hold", 6'd18, 26'h0);
    end
    reset = 1'b0;
    chk("rst_rel", 6'd18, 26'h20C0000);

    // ADD with zero-wait memory
    mem_ready = 1'b1; ir_op = 4'd1;
    fetch();
    tick(); chk("add1", 6'd1, 26'h0310400);
    tick(); chk("add_ret", 6'd18, 26'h20C0000);

    // Fetch with three wait cycles, then a not-taken branch
    mem_ready = 1'b0; ir_op = 4'd0; ben = 1'b0;
    tick(); chk("wait33_1", 6'd33, 26'h000000A);
    tick(); chk("wait33_2", 6'd33, 26'h000000A);
    tick(); chk("wait33_3", 6'd33, 26'h000000A);
    mem_ready = 1'b1;
    chk("wait33_4", 6'd33, 26'h100000A);
    tick(); chk("wait35", 6'd35, 26'h0820000);
    tick(); chk("brn32", 6'd32, 26'h0400000);
    tick(); chk("brn0", 6'd0, 26'h0);
    tick(); chk("brn_ret", 6'd18, 26'h20C0000);

    // Taken branch
    ben = 1'b1;
    fetch();
    tick(); chk("brt0", 6'd0, 26'h0);
    tick(); chk("brt22", 6'd22, 26'h0082101);
    tick(); chk("brt_ret", 6'd18, 26'h20C0000);

    // JSR with offset, then JSRR
    ir_op = 4'd4; ir11 = 1'b1;
    fetch();
    tick(); chk("jsr4", 6'd4, 26'h0240800);
    tick(); chk("jsr21", 6'd21, 26'h0082181);
    tick(); chk("jsr_ret", 6'd18, 26'h20C0000);
    ir11 = 1'b0;
    fetch();
    tick(); chk("jsrr4", 6'd4, 26'h0240800);
    tick(); chk("jsrr20", 6'd20, 26'h0082600);
    tick(); chk("jsrr_ret", 6'd18, 26'h20C0000);

    // Reserved opcode falls straight back to fetch
    ir_op = 4'd8;
    fetch();
    tick(); chk("nop_ret", 6'd18, 26'h20C0000);

    // STW
    ir_op = 4'd7;
    fetch();
    tick(); chk("stw7", 6'd7, 26'h20086C1);
    tick(); chk("stw23", 6'd23, 26'h1010032);
    tick(); chk("stw16", 6'd16, 26'h000000E);
    tick(); chk("stw_ret", 6'd18, 26'h20C0000);

    // TRAP
    ir_op = 4'd15;
    fetch();
    tick(); chk("trap15", 6'd15, 26'h2008000);
    tick(); chk("trap28", 6'd28, 26'h124080A);
    tick(); chk("trap30", 6'd30, 26'h00A1002);
    tick(); chk("trap_ret", 6'd18, 26'h20C0000);

    // LDW stalled in 25, reset mid-instruction
    ir_op = 4'd6;
    fetch();
    tick(); chk("ldw6", 6'd6, 26'h20086C1);
    mem_ready = 1'b0;
    tick(); chk("ldw25", 6'd25, 26'h000000A);
    tick(); chk("ldw25_hold", 6'd25, 26'h000000A);
    reset = 1'b1;
    chk("midrst_word", 6'd25, 26'h0);
    tick(); chk("midrst_18", 6'd18, 26'h0);
    tick(); chk("midrst_hold", 6'd18, 26'h0);
    reset = 1'b0; mem_ready = 1'b1;
    chk("midrst_rel", 6'd18, 26'h20C0000);
    tick(); chk("midrst_33", 6'd33, 26'h100000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
